// File: rtl/fault_monitor.sv
// Fault monitor for a laser fault-injection register array: counts q/golden mismatches and
// captures the first syndrome. Optional FAULT_MASK_EN adds a cumulative flipped-bit mask.
module fault_monitor #(
    parameter int unsigned N             = 8,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned SETTLE_CYC    = 4,
    parameter bit          HALT_ON_FAULT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arm,
    input  logic             disarm,
    input  logic [N-1:0]     q,
    input  logic [N-1:0]     golden,
    output logic             fault_pulse,
    output logic             fault_sticky,
    output logic [CNT_W-1:0] fault_count,
    output logic [N-1:0]     first_syndrome,
`ifdef FAULT_MASK_EN
    output logic [N-1:0]     fault_mask,
`endif
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StSettle  = 2'd1,
        StMonitor = 2'd2,
        StHalt    = 2'd3
    } state_e;

    localparam int unsigned     SetW     = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SetW-1:0] SetLoad  = SetW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] CntMax  = '1;
    localparam state_e          ArmState = (SETTLE_CYC == 0) ? StMonitor : StSettle;

    state_e             state_q, state_d;
    logic [SetW-1:0]    settle_q, settle_d;
    logic [N-1:0]       q_q, golden_q;
    logic               pulse_q, pulse_d;
    logic               sticky_q, sticky_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [N-1:0]       syn_q, syn_d;
    logic [N-1:0]       syndrome;
    logic               mismatch;
`ifdef FAULT_MASK_EN
    logic [N-1:0]       mask_q, mask_d;
`endif

    assign syndrome = q_q ^ golden_q;
    assign mismatch = |syndrome;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        pulse_d  = 1'b0;
        sticky_d = sticky_q;
        count_d  = count_q;
        syn_d    = syn_q;
`ifdef FAULT_MASK_EN
        mask_d   = mask_q;
`endif
        // disarm beats arm; results are held on disarm
        if (disarm) begin
            state_d = StIdle;
        end else if (arm) begin
            state_d  = ArmState;
            settle_d = SetLoad;
            sticky_d = 1'b0;
            count_d  = '0;
            syn_d    = '0;
`ifdef FAULT_MASK_EN
            mask_d   = '0;
`endif
        end else begin
            unique case (state_q)
                StSettle: begin
                    if (settle_q == '0) begin
                        state_d = StMonitor;
                    end else begin
                        settle_d = settle_q - 1'b1;
                    end
                end
                StMonitor: begin
                    if (mismatch) begin
                        pulse_d = 1'b1;
                        if (count_q != CntMax) begin
                            count_d = count_q + 1'b1;
                        end
                        if (!sticky_q) begin
                            sticky_d = 1'b1;
                            syn_d    = syndrome;
                        end
`ifdef FAULT_MASK_EN
                        mask_d = mask_q | syndrome;
`endif
                        if (HALT_ON_FAULT) begin
                            state_d = StHalt;
                        end
                    end
                end
                StIdle, StHalt: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            settle_q <= '0;
            q_q      <= '0;
            golden_q <= '0;
            pulse_q  <= 1'b0;
            sticky_q <= 1'b0;
            count_q  <= '0;
            syn_q    <= '0;
`ifdef FAULT_MASK_EN
            mask_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            q_q      <= q;
            golden_q <= golden;
            pulse_q  <= pulse_d;
            sticky_q <= sticky_d;
            count_q  <= count_d;
            syn_q    <= syn_d;
`ifdef FAULT_MASK_EN
            mask_q   <= mask_d;
`endif
        end
    end

    assign state          = state_q;
    assign fault_pulse    = pulse_q;
    assign fault_sticky   = sticky_q;
    assign fault_count    = count_q;
    assign first_syndrome = syn_q;
`ifdef FAULT_MASK_EN
    assign fault_mask     = mask_q;
`endif

endmodule

// File: tb/tb_fault_monitor.sv
// Bench for fault_monitor: three configurations (default, CNT_W=2, HALT_ON_FAULT=1) share one
// stimulus stream and are compared every cycle against a behavioural model.
module tb_fault_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic       arm, disarm;
    logic [7:0] q, golden;

    logic        pl0, pl1, pl2, st0, st1, st2;
    logic [15:0] cnt0, cnt2;
    logic [1:0]  cnt1;
    logic [7:0]  syn0, syn1, syn2;
    logic [1:0]  sta0, sta1, sta2;
`ifdef FAULT_MASK_EN
    logic [7:0]  fm0, fm1, fm2;
`endif

    int total = 0;
    int bad   = 0;

    // model: mode uses the spec's state numbering, rem = SETTLE cycles still to dwell
    int         m_mode [3];
    int         m_rem  [3];
    int         m_cnt  [3];
    int         m_pulse[3];
    int         m_stk  [3];
    logic [7:0] m_syn  [3];
    logic [7:0] m_mask [3];
    int         cnt_max[3] = '{65535, 3, 65535};
    int         halt   [3] = '{0, 0, 1};
    logic [7:0] pq, pg;

    always #5 clk = ~clk;

    fault_monitor #(.N(8), .CNT_W(16), .SETTLE_CYC(4), .HALT_ON_FAULT(1'b0)) dut0 (
        .clk(clk), .reset(reset), .arm(arm), .disarm(disarm), .q(q), .golden(golden),
        .fault_pulse(pl0), .fault_sticky(st0), .fault_count(cnt0), .first_syndrome(syn0),
`ifdef FAULT_MASK_EN
        .fault_mask(fm0),
`endif
        .state(sta0)
    );

    fault_monitor #(.N(8), .CNT_W(2), .SETTLE_CYC(4), .HALT_ON_FAULT(1'b0)) dut1 (
        .clk(clk), .reset(reset), .arm(arm), .disarm(disarm), .q(q), .golden(golden),
        .fault_pulse(pl1), .fault_sticky(st1), .fault_count(cnt1), .first_syndrome(syn1),
`ifdef FAULT_MASK_EN
        .fault_mask(fm1),
`endif
        .state(sta1)
    );

    fault_monitor #(.N(8), .CNT_W(16), .SETTLE_CYC(4), .HALT_ON_FAULT(1'b1)) dut2 (
        .clk(clk), .reset(reset), .arm(arm), .disarm(disarm), .q(q), .golden(golden),
        .fault_pulse(pl2), .fault_sticky(st2), .fault_count(cnt2), .first_syndrome(syn2),
`ifdef FAULT_MASK_EN
        .fault_mask(fm2),
`endif
        .state(sta2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_mode[i] = 0; m_rem[i] = 0; m_cnt[i] = 0; m_pulse[i] = 0;
            m_stk[i] = 0; m_syn[i] = '0; m_mask[i] = '0;
        end
        pq = '0;
        pg = '0;
    endtask

    task automatic model_step();
        logic [7:0] s;
        s = pq ^ pg;
        for (int i = 0; i < 3; i++) begin
            m_pulse[i] = 0;
            if (disarm) begin
                m_mode[i] = 0;
            end else if (arm) begin
                m_cnt[i] = 0; m_stk[i] = 0; m_syn[i] = '0; m_mask[i] = '0;
                m_mode[i] = 1;
                m_rem[i]  = 4;
            end else if (m_mode[i] == 1) begin
                if (m_rem[i] == 1) m_mode[i] = 2;
                else m_rem[i]--;
            end else if (m_mode[i] == 2 && s != 0) begin
                m_pulse[i] = 1;
                if (m_cnt[i] < cnt_max[i]) m_cnt[i]++;
                if (m_stk[i] == 0) begin
                    m_stk[i] = 1;
                    m_syn[i] = s;
                end
                m_mask[i] = m_mask[i] | s;
                if (halt[i] != 0) m_mode[i] = 3;
            end
        end
        pq = q;
        pg = golden;
    endtask

    task automatic check_all();
        check("d0_state", 32'(sta0), 32'(m_mode[0]));
        check("d0_pulse", 32'(pl0), 32'(m_pulse[0]));
        check("d0_sticky", 32'(st0), 32'(m_stk[0]));
        check("d0_count", 32'(cnt0), 32'(m_cnt[0]));
        check("d0_syn", 32'(syn0), 32'(m_syn[0]));
        check("d1_state", 32'(sta1), 32'(m_mode[1]));
        check("d1_pulse", 32'(pl1), 32'(m_pulse[1]));
        check("d1_count", 32'(cnt1), 32'(m_cnt[1]));
        check("d1_syn", 32'(syn1), 32'(m_syn[1]));
        check("d2_state", 32'(sta2), 32'(m_mode[2]));
        check("d2_pulse", 32'(pl2), 32'(m_pulse[2]));
        check("d2_sticky", 32'(st2), 32'(m_stk[2]));
        check("d2_count", 32'(cnt2), 32'(m_cnt[2]));
        check("d2_syn", 32'(syn2), 32'(m_syn[2]));
`ifdef FAULT_MASK_EN
        check("d0_mask", 32'(fm0), 32'(m_mask[0]));
        check("d1_mask", 32'(fm1), 32'(m_mask[1]));
        check("d2_mask", 32'(fm2), 32'(m_mask[2]));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        #1;
        check_all();
    endtask

    task automatic cyc(input logic a, input logic d, input logic [7:0] qq, input logic [7:0] gg);
        arm = a; disarm = d; q = qq; golden = gg;
        tick();
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; disarm = 1'b0; q = 8'hA5; golden = 8'hA5;
        #1;
        model_reset();
        check_all();
        tick();
        reset = 1'b0;
        tick();

        // 1: arm, clean data, four SETTLE cycles then MONITOR
        cyc(1'b1, 1'b0, 8'hA5, 8'hA5);
        check("t1_settle", 32'(sta0), 32'd1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 8'hA5, 8'hA5);
        check("t1_monitor", 32'(sta0), 32'd2);

        // 2: single-cycle fault, pulse two edges later
        cyc(1'b0, 1'b0, 8'hA4, 8'hA5);
        check("t2_no_pulse_yet", 32'(pl0), 32'd0);
        cyc(1'b0, 1'b0, 8'hA5, 8'hA5);
        check("t2_pulse", 32'(pl0), 32'd1);
        check("t2_syn", 32'(syn0), 32'h01);
        cyc(1'b0, 1'b0, 8'hA5, 8'hA5);
        check("t2_pulse_off", 32'(pl0), 32'd0);

        // 3: two more faults
        cyc(1'b0, 1'b0, 8'h25, 8'hA5);
        cyc(1'b0, 1'b0, 8'hA5, 8'hA5);
        cyc(1'b0, 1'b0, 8'hA7, 8'hA5);
        cyc(1'b0, 1'b0, 8'hA5, 8'hA5);
        cyc(1'b0, 1'b0, 8'hA5, 8'hA5);
        check("t3_count", 32'(cnt0), 32'd3);
        check("t3_syn", 32'(syn0), 32'h01);
`ifdef FAULT_MASK_EN
        check("t3_mask", 32'(fm0), 32'h83);
`endif

        // 4: held mismatch saturates the 2-bit counter
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 8'h00, 8'hA5);
        cyc(1'b0, 1'b0, 8'hA5, 8'hA5);
        cyc(1'b0, 1'b0, 8'hA5, 8'hA5);
        check("t4_sat", 32'(cnt1), 32'd3);
        check("t4_count", 32'(cnt0), 32'd9);

        // 5: restart, then halt-on-fault with full syndrome
        cyc(1'b1, 1'b0, 8'hFF, 8'hFF);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 8'hFF, 8'hFF);
        cyc(1'b0, 1'b0, 8'h00, 8'hFF);
        cyc(1'b0, 1'b0, 8'hFF, 8'hFF);
        check("t5_halt", 32'(sta2), 32'd3);
        check("t5_syn", 32'(syn2), 32'hFF);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h00, 8'hFF);
        cyc(1'b0, 1'b0, 8'hFF, 8'hFF);
        check("t5_hold", 32'(cnt2), 32'd1);

        // 6: arm+disarm together, then re-arm, then async reset in SETTLE
        cyc(1'b1, 1'b1, 8'h00, 8'hFF);
        check("t6_idle", 32'(sta0), 32'd0);
        check("t6_held", 32'(cnt0), 32'd4);
        cyc(1'b0, 1'b0, 8'hFF, 8'hFF);
        cyc(1'b1, 1'b0, 8'h0F, 8'hFF);
        check("t6_clr", 32'(cnt0), 32'd0);
        cyc(1'b0, 1'b0, 8'h0F, 8'hFF);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        tick();
        reset = 1'b0;
        arm = 1'b0;
        tick();

        // random traffic
        for (int n = 0; n < 600; n++) begin
            logic [7:0] g;
            logic [7:0] f;
            g = ($urandom_range(0, 7) == 0) ? 8'($urandom) : golden;
            f = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            cyc(($urandom_range(0, 29) == 0), ($urandom_range(0, 39) == 0), g ^ f, g);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fault_monitor.md
Name: fault_monitor

Overview:
- Downstream consumer of the N-bit register array used as the laser fault-injection target.
- Samples the array's q bus every clock and compares it against a golden word, the value the array should hold.
- Counts mismatch cycles and captures the first fault syndrome, so the host can tell whether and where a laser shot flipped register bits.
- Runs in the same 100 MHz MMCM-derived clock domain as the register array; no CDC inside.

Parameters:
N, 8, width of monitored register bus (≥1)
CNT_W, 16, width of fault counter (≥2)
SETTLE_CYC, 4, cycles to ignore after arm while the array loads (0 allowed)
HALT_ON_FAULT, 0, 1 = freeze monitoring after first fault; 0 = keep counting

Ports:
clk  input  1  system clock (MMCM output, 100 MHz)
reset  input  1  asynchronous, active-high reset
arm  input  1  single-cycle start/restart request
disarm  input  1  single-cycle stop request
q  input  N  register-array output under observation
golden  input  N  expected value of q
fault_pulse  output  1  high for one cycle per mismatching sample in MONITOR
fault_sticky  output  1  set on first fault since arm
fault_count  output  CNT_W  number of mismatching sample cycles, saturating
first_syndrome  output  N  q XOR golden at first fault
state  output  2  0=IDLE 1=SETTLE 2=MONITOR 3=HALT

Behaviour:
- Reset (async assert, sync release):
  - All outputs, state, pipeline registers and settle counter go to 0.
  - state=IDLE.
- Input stage:
  - q_r<=q and golden_r<=golden on every edge, in all states.
  - syndrome = q_r ^ golden_r (combinational); mismatch = |syndrome.
- Latency:
  - A q value presented before edge k is compared in the cycle after edge k.
  - Its fault_pulse, fault_count increment and capture happen at edge k+1.
- Priority when arm and disarm coincide: disarm > arm.
- IDLE:
  - arm → clear fault_count, fault_sticky and first_syndrome.
  - Then go to SETTLE with settle counter = SETTLE_CYC-1, or straight to MONITOR if SETTLE_CYC=0.
  - Outputs from the previous run are held until that arm.
- SETTLE:
  - Mismatches ignored.
  - Counter decrements each cycle; when it is 0 → MONITOR.
  - Total SETTLE dwell = SETTLE_CYC cycles.
- MONITOR, each cycle:
  - If mismatch: fault_pulse<=1 and fault_count<=fault_count+1, saturating at 2^CNT_W-1 (no wrap).
  - If mismatch and fault_sticky=0: first_syndrome<=syndrome and fault_sticky<=1.
  - If mismatch and HALT_ON_FAULT=1 → HALT after that update.
  - Otherwise fault_pulse<=0.
- HALT:
  - No further counting; fault_pulse=0.
  - Results are held.
- disarm in SETTLE/MONITOR/HALT → IDLE on next edge.
  - fault_pulse forced 0; the mismatch in that same cycle is not counted.
  - Counters and syndrome are held.
- arm in SETTLE/MONITOR/HALT (without disarm) → full restart: clear results, reload settle counter, enter SETTLE (or MONITOR if SETTLE_CYC=0).
  - A mismatch in the arm cycle is not counted.
- disarm in IDLE: no effect.
- Reset mid-operation aborts immediately to the reset values.
- fault_pulse is never high outside MONITOR.

Optional Feature:
FAULT_MASK_EN
- Defined: adds output fault_mask [N].
  - fault_mask accumulates the bitwise OR of every syndrome counted in MONITOR.
  - It is cleared by reset and arm, and held in IDLE/HALT.
  - It identifies all bits ever flipped, not just those in the first fault.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
1. Reset, then arm with SETTLE_CYC=4, q=golden=8'hA5 throughout → state goes 1 for 4 cycles then 2; fault_count=0, fault_sticky=0, fault_pulse never asserted.
2. In MONITOR, drive q=8'hA4 for one cycle (golden=8'hA5) → fault_pulse high exactly 2 edges later for 1 cycle; fault_count=1; first_syndrome=8'h01; fault_sticky=1.
3. Two later faults, q=8'h25 then q=8'hA7 (3 mismatch cycles total) → fault_count=3; first_syndrome stays 8'h01. With FAULT_MASK_EN, fault_mask=8'h83.
4. Set CNT_W=2 and hold a mismatch for 6 cycles → fault_count reaches 3 and stays 3.
5. Set HALT_ON_FAULT=1 and inject q=8'h00 vs golden=8'hFF → state=3; fault_count=1; first_syndrome=8'hFF; further mismatches do not change outputs.
6. Assert arm and disarm in the same cycle while in MONITOR → state=0 and results held. Then pulse arm → results cleared to 0 and state=1. Assert reset during SETTLE → all outputs 0 asynchronously.
